pwm_generator_mc: RTL and testbench

Multi-channel PWM timer for the power stage: one shared period counter, edge- or center-aligned, drives `channels` comparators. Each comparator produces a complementary high/low gate pair with programmable dead time. Period, compare and dead-time values pass through shadow registers that are applied only at the period boundary, so the control loop can write at any time without glitching the gates. The block sits between the controller output (duty computation) and the gate-driver pins, and supplies the ADC trigger (`sync`).

---
 rtl/pwm_pkg.sv | 28 ++
 rtl/pwm_deadtime.sv | 68 ++++++
 rtl/pwm_generator_mc.sv | 128 ++++++++++++
 tb/tb_pwm_generator_mc.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// ============================================================================
// pwm_pkg : shared constants and types for the multi-channel PWM timer
// Rev 1.0
// ============================================================================
`default_nettype none

package pwm_pkg;

  localparam logic PWM_EDGE   = 1'b0;
  localparam logic PWM_CENTER = 1'b1;

  localparam int PWM_COUNTER_WIDTH  = 12;
  localparam int PWM_CHANNELS       = 2;
  localparam int PWM_DEADTIME_WIDTH = 8;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  // LSB of channel k inside a packed per-channel bus of slice width w
  function automatic int pwm_slice_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_deadtime.sv
// ============================================================================
// pwm_deadtime : complementary gate pair with dead-time insertion, one channel
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int deadtime_width = PWM_DEADTIME_WIDTH
) (
  input  logic                      aclk,
  input  logic                      resetn,
  input  logic                      enable,
  input  logic                      raw,
  input  logic [deadtime_width-1:0] deadtime,
  output logic                      pwm_h,
  output logic                      pwm_l
);

  logic [deadtime_width-1:0] dt_cnt_q, dt_cnt_d;
  logic raw_q, off_q;
  logic h_q, h_d, l_q, l_d;
  logic edge_seen, hold;

  // Coming out of disable/reset counts as an edge so the first gate also waits D
  assign edge_seen = off_q || (raw != raw_q);
  assign hold      = edge_seen ? (deadtime != '0) : (dt_cnt_q > deadtime_width'(1));

  always_comb begin
    dt_cnt_d = '0;
    h_d      = 1'b0;
    l_d      = 1'b0;
    if (enable) begin
      if (edge_seen) begin
        dt_cnt_d = deadtime;
      end else if (dt_cnt_q != '0) begin
        dt_cnt_d = dt_cnt_q - deadtime_width'(1);
      end
      if (!hold) begin
        h_d = raw;
        l_d = ~raw;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      dt_cnt_q <= '0;
      raw_q    <= 1'b0;
      off_q    <= 1'b1;
      h_q      <= 1'b0;
      l_q      <= 1'b0;
    end else begin
      dt_cnt_q <= dt_cnt_d;
      raw_q    <= raw;
      off_q    <= ~enable;
      h_q      <= h_d;
      l_q      <= l_d;
    end
  end

  assign pwm_h = h_q;
  assign pwm_l = l_q;

endmodule

`default_nettype wire

// File: rtl/pwm_generator_mc.sv
// ============================================================================
// pwm_generator_mc : shared edge/center-aligned counter, shadowed compares,
//                    per-channel dead-time gate pairs and ADC sync
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_generator_mc
  import pwm_pkg::*;
#(
  parameter int counter_width  = PWM_COUNTER_WIDTH,
  parameter int channels       = PWM_CHANNELS,
  parameter int deadtime_width = PWM_DEADTIME_WIDTH
) (
  input  logic                              aclk,
  input  logic                              resetn,
  input  logic                              enable,
  input  logic                              mode,
  input  logic [counter_width-1:0]          period,
  input  logic [channels*counter_width-1:0] comparator,
  input  logic [deadtime_width-1:0]         deadtime,
  input  logic                              update,
  output logic [counter_width-1:0]          counter,
  output logic                              sync,
  output logic [channels-1:0]               pwm_h,
  output logic [channels-1:0]               pwm_l
);

  logic [counter_width-1:0]          cnt_q, cnt_d;
  pwm_dir_e                          dir_q, dir_d;
  logic                              sync_q, sync_d;
  logic [counter_width-1:0]          per_q, per_d;
  logic [channels*counter_width-1:0] cmp_q, cmp_d;
  logic [deadtime_width-1:0]         dt_q, dt_d;
  logic                              mode_q, mode_d;
  logic                              pend_q, pend_d;
  logic                              pe, load;
  logic [channels-1:0]               raw;

  always_comb begin
    if (mode_q == PWM_EDGE) begin
      pe = (cnt_q == per_q);
    end else begin
      pe = ((dir_q == DIR_DOWN) && (cnt_q == counter_width'(1))) || (per_q == '0);
    end
  end

  // Shadow registers track the inputs freely while the timer is stopped
  assign load = !enable || (pe && (pend_q || update));

  always_comb begin
    per_d  = per_q;
    cmp_d  = cmp_q;
    dt_d   = dt_q;
    mode_d = mode_q;
    pend_d = pend_q | update;
    if (load) begin
      per_d  = period;
      cmp_d  = comparator;
      dt_d   = deadtime;
      mode_d = mode;
      pend_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = '0;
    dir_d = DIR_UP;
    if (enable && !pe) begin
      if (mode_q == PWM_EDGE) begin
        cnt_d = cnt_q + counter_width'(1);
      end else if (dir_q == DIR_UP) begin
        cnt_d = cnt_q + counter_width'(1);
        dir_d = (cnt_d == per_q) ? DIR_DOWN : DIR_UP;
      end else begin
        cnt_d = cnt_q - counter_width'(1);
        dir_d = DIR_DOWN;
      end
    end
    sync_d = enable && (cnt_d == '0);
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      sync_q <= 1'b0;
      per_q  <= '0;
      cmp_q  <= '0;
      dt_q   <= '0;
      mode_q <= PWM_EDGE;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      sync_q <= sync_d;
      per_q  <= per_d;
      cmp_q  <= cmp_d;
      dt_q   <= dt_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
    end
  end

  assign counter = cnt_q;
  assign sync    = sync_q;

  generate
    for (genvar k = 0; k < channels; k++) begin : g_ch
      assign raw[k] = cnt_q < cmp_q[pwm_slice_lsb(k, counter_width) +: counter_width];

      pwm_deadtime #(
        .deadtime_width(deadtime_width)
      ) u_deadtime (
        .aclk    (aclk),
        .resetn  (resetn),
        .enable  (enable),
        .raw     (raw[k]),
        .deadtime(dt_q),
        .pwm_h   (pwm_h[k]),
        .pwm_l   (pwm_l[k])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pwm_generator_mc.sv
// ============================================================================
// tb_pwm_generator_mc : scoreboard bench with a period/phase reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pwm_generator_mc;

  localparam int CW = 12;
  localparam int CH = 2;
  localparam int DW = 8;

  logic             clk;
  logic             resetn;
  logic             enable;
  logic             mode;
  logic [CW-1:0]    period;
  logic [CH*CW-1:0] comparator;
  logic [DW-1:0]    deadtime;
  logic             update;
  logic [CW-1:0]    counter;
  logic             sync;
  logic [CH-1:0]    pwm_h;
  logic [CH-1:0]    pwm_l;

  pwm_generator_mc #(
    .counter_width (CW),
    .channels      (CH),
    .deadtime_width(DW)
  ) dut (
    .aclk      (clk),
    .resetn    (resetn),
    .enable    (enable),
    .mode      (mode),
    .period    (period),
    .comparator(comparator),
    .deadtime  (deadtime),
    .update    (update),
    .counter   (counter),
    .sync      (sync),
    .pwm_h     (pwm_h),
    .pwm_l     (pwm_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          cnt;
    bit          sync;
    bit [CH-1:0] h;
    bit [CH-1:0] l;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, expv);
    end
  endtask

  // Reference model: position within the period, run-length of raw per channel
  int m_P, m_D, m_phase;
  int m_cmp[CH];
  bit m_mode, m_pend;
  int run_start[CH];
  int run_D[CH];
  bit run_raw[CH];
  bit run_ok[CH];

  function automatic int len_of(input int p, input bit md);
    if (md) return (p == 0) ? 1 : 2 * p;
    return p + 1;
  endfunction

  function automatic int cnt_of(input int ph, input int p, input bit md);
    if (md && ph > p) return 2 * p - ph;
    return ph;
  endfunction

  task automatic load_inputs();
    m_P    = int'(period);
    m_D    = int'(deadtime);
    m_mode = mode;
    for (int k = 0; k < CH; k++) m_cmp[k] = int'(comparator[k*CW +: CW]);
  endtask

  task automatic model_step();
    exp_t e;
    bit   en, rw, pe;
    int   cur;
    en  = resetn && enable;
    cur = cnt_of(m_phase, m_P, m_mode);
    e.cyc = cyc + 1;
    for (int k = 0; k < CH; k++) begin
      rw = cur < m_cmp[k];
      if (!en) begin
        run_ok[k] = 1'b0;
        e.h[k] = 1'b0;
        e.l[k] = 1'b0;
      end else begin
        if (!run_ok[k] || rw != run_raw[k]) begin
          run_ok[k]    = 1'b1;
          run_raw[k]   = rw;
          run_start[k] = cyc;
          run_D[k]     = m_D;
        end
        e.h[k] = rw && ((cyc - run_start[k]) >= run_D[k]);
        e.l[k] = !rw && ((cyc - run_start[k]) >= run_D[k]);
      end
    end
    if (!resetn) begin
      m_P = 0; m_D = 0; m_mode = 1'b0; m_pend = 1'b0; m_phase = 0;
      for (int k = 0; k < CH; k++) m_cmp[k] = 0;
    end else if (!enable) begin
      load_inputs();
      m_pend  = 1'b0;
      m_phase = 0;
    end else begin
      pe = (m_phase == len_of(m_P, m_mode) - 1);
      if (pe && (m_pend || update)) begin
        load_inputs();
        m_pend = 1'b0;
      end else if (update) begin
        m_pend = 1'b1;
      end
      m_phase = pe ? 0 : m_phase + 1;
    end
    e.cnt  = cnt_of(m_phase, m_P, m_mode);
    e.sync = en && (e.cnt == 0);
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input int p, input int c0, input int c1, input int d, input bit md);
    period     = CW'(p);
    comparator = {CW'(c1), CW'(c0)};
    deadtime   = DW'(d);
    mode       = md;
  endtask

  // Stop, load the new setting directly, then run
  task automatic seg(input int p, input int c0, input int c1, input int d, input bit md, input int n);
    set_in(p, c0, c1, d, md);
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(n);
  endtask

  // Monitor: pop and compare whenever the scheduled cycle is presented
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("counter", int'(counter), e.cnt);
        chk("sync", int'(sync), int'(e.sync));
        chk("pwm_h", int'(pwm_h), int'(e.h));
        chk("pwm_l", int'(pwm_l), int'(e.l));
      end
      if (cyc > 0) chk("no_overlap", int'(pwm_h & pwm_l), 0);
    end
  end

  initial begin
    resetn = 1'b0; enable = 1'b0; update = 1'b0;
    set_in(0, 0, 0, 0, 1'b0);
    m_P = 0; m_D = 0; m_mode = 1'b0; m_pend = 1'b0; m_phase = 0;
    for (int k = 0; k < CH; k++) begin
      m_cmp[k] = 0; run_ok[k] = 1'b0; run_raw[k] = 1'b0; run_start[k] = 0; run_D[k] = 0;
    end
    tick(3);
    resetn = 1'b1;

    seg(9, 3, 0, 0, 1'b0, 40);
    seg(8, 0, 2, 0, 1'b1, 48);
    seg(19, 10, 0, 3, 1'b0, 60);

    seg(9, 3, 5, 0, 1'b0, 15);
    set_in(9, 6, 5, 0, 1'b0);
    tick(15);
    update = 1'b1; tick(1); update = 1'b0;
    tick(30);

    seg(9, 0, 10, 0, 1'b0, 25);
    seg(0, 1, 0, 0, 1'b0, 10);
    seg(0, 1, 0, 2, 1'b1, 10);
    seg(19, 2, 0, 3, 1'b0, 45);

    seg(19, 10, 0, 3, 1'b0, 25);
    enable = 1'b0; tick(1); enable = 1'b1;
    tick(30);
    resetn = 1'b0; tick(1); resetn = 1'b1;
    set_in(11, 4, 9, 2, 1'b1);
    update = 1'b1; tick(1); update = 1'b0;
    tick(40);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0)
        set_in($urandom_range(0, 20), $urandom_range(0, 22), $urandom_range(0, 22),
               $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      update = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 79) == 0) enable = ~enable;
      resetn = ($urandom_range(0, 199) != 0);
      tick(1);
    end
    update = 1'b0;
    resetn = 1'b1;

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
